// File: rtl/ram_pkg.sv
// Package for the ram_sync_init slice.
// Contents:
//   ram_state_e  - sequencer state (CLEAR: zeroing the array, IDLE: serving accesses)
//   even_par()   - even-parity bit of a data word (zero-extended to ParMaxWidth bits)
package ram_pkg;

  typedef enum logic {CLEAR, IDLE} ram_state_e;

  // Widest data word the parity helper accepts; callers zero-extend, which leaves parity unchanged.
  localparam int unsigned ParMaxWidth = 256;

  function automatic logic even_par(input logic [ParMaxWidth-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_sync_array.sv
// Storage array for ram_sync_init: one write port and one registered read port.
// Ports:
//   clk_i    clock, all activity on posedge
//   we_i     write enable; wdata_i written to mem[waddr_i]
//   waddr_i  write address (must be < Depth when we_i=1)
//   wdata_i  write data
//   re_i     read enable; rdata_o loads mem[raddr_i], otherwise holds
//   raddr_i  read address (must be < Depth when re_i=1)
//   rdata_o  registered read data
module ram_sync_array #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  parameter int unsigned Aw    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // No reset: the top decides when rdata_o is actually driven onto its output.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sync_init.sv
// Single-port synchronous RAM with hardware clear sequencer.
// Clocked write, 1-cycle registered read with out_valid strobe, optional write echo (WR_ECHO),
// out-of-range address flag, and an array clear after reset or on clr.
// Optional feature macro: RAM_PARITY_EN (per-word even parity, pinj inject, perr strobe).
// Ports:
//   clk        clock (posedge)             rst        synchronous active-high reset
//   D          write data                  addr       word address
//   w          1 = write, 0 = read         en         access request
//   clr        request full-array clear    pinj       invert stored parity on write
//   out        registered read data        out_valid  strobe: out updated this cycle
//   busy       1 while clearing            addr_err   strobe: access with addr >= DEPTH
//   perr       strobe with out_valid: stored parity mismatch
module ram_sync_init
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 8,
  parameter bit          WR_ECHO = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         D,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     w,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     pinj,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     addr_err,
  output logic                     perr
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef RAM_PARITY_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif

  ram_state_e     state_q, state_d;
  logic [AW-1:0]  clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0] out_q, out_d;
  // 1: out shows the array read register; 0: out shows out_q (echo / out-of-range zero).
  logic           src_arr_q, src_arr_d;
  logic           out_valid_q, out_valid_d;
  logic           addr_err_q, addr_err_d;

  logic           arr_we, arr_re;
  logic [AW-1:0]  arr_waddr;
  logic [MW-1:0]  arr_wdata, arr_rdata, wr_word;
  logic [31:0]    addr_ext;
  logic           in_range;

  // Compared at 32 bits so a power-of-two DEPTH does not wrap the limit to zero.
  assign addr_ext = 32'(addr);
  assign in_range = addr_ext < DEPTH;

`ifdef RAM_PARITY_EN
  assign wr_word = {even_par(ParMaxWidth'(D)) ^ pinj, D};
`else
  logic unused_pinj;
  assign unused_pinj = pinj;
  assign wr_word     = D;
`endif

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    out_d       = out_q;
    src_arr_d   = src_arr_q;
    out_valid_d = 1'b0;
    addr_err_d  = 1'b0;
    arr_we      = 1'b0;
    arr_re      = 1'b0;
    arr_waddr   = addr;
    arr_wdata   = wr_word;
    unique case (state_q)
      CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = clr_ptr_q;
        arr_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else if (en) begin
          if (!in_range) begin
            addr_err_d = 1'b1;
            if (!w) begin
              out_d       = '0;
              src_arr_d   = 1'b0;
              out_valid_d = 1'b1;
            end
          end else if (w) begin
            arr_we = 1'b1;
            if (WR_ECHO) begin
              out_d       = D;
              src_arr_d   = 1'b0;
              out_valid_d = 1'b1;
            end
          end else begin
            arr_re      = 1'b1;
            src_arr_d   = 1'b1;
            out_valid_d = 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      out_q       <= '0;
      src_arr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      out_q       <= out_d;
      src_arr_q   <= src_arr_d;
      out_valid_q <= out_valid_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Reset drops any in-flight array access.
  ram_sync_array #(
    .Width (MW),
    .Depth (DEPTH),
    .Aw    (AW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we & ~rst),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (arr_re & ~rst),
    .raddr_i (addr),
    .rdata_o (arr_rdata)
  );

  assign out       = src_arr_q ? arr_rdata[WIDTH-1:0] : out_q;
  assign out_valid = out_valid_q;
  assign addr_err  = addr_err_q;
  assign busy      = (state_q == CLEAR);

`ifdef RAM_PARITY_EN
  assign perr = out_valid_q & src_arr_q &
                (arr_rdata[WIDTH] != even_par(ParMaxWidth'(arr_rdata[WIDTH-1:0])));
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sync_init.sv
// Self-checking bench for ram_sync_init.
// u0: DEPTH=8 WR_ECHO=0, u1: DEPTH=8 WR_ECHO=1, u2: DEPTH=6 WR_ECHO=0; all share stimulus.
module tb_ram_sync_init;

  logic       clk = 1'b0;
  logic       rst, w, en, clr, pinj;
  logic [7:0] d;
  logic [2:0] addr;

  logic [7:0] out0, out1, out2;
  logic       ov0, ov1, ov2, busy0, busy1, busy2, ae0, ae1, ae2, pe0, pe1, pe2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_sync_init #(.WIDTH(8), .DEPTH(8), .WR_ECHO(1'b0)) u0 (
    .clk(clk), .rst(rst), .D(d), .addr(addr), .w(w), .en(en), .clr(clr), .pinj(pinj),
    .out(out0), .out_valid(ov0), .busy(busy0), .addr_err(ae0), .perr(pe0)
  );
  ram_sync_init #(.WIDTH(8), .DEPTH(8), .WR_ECHO(1'b1)) u1 (
    .clk(clk), .rst(rst), .D(d), .addr(addr), .w(w), .en(en), .clr(clr), .pinj(pinj),
    .out(out1), .out_valid(ov1), .busy(busy1), .addr_err(ae1), .perr(pe1)
  );
  ram_sync_init #(.WIDTH(8), .DEPTH(6), .WR_ECHO(1'b0)) u2 (
    .clk(clk), .rst(rst), .D(d), .addr(addr), .w(w), .en(en), .clr(clr), .pinj(pinj),
    .out(out2), .out_valid(ov2), .busy(busy2), .addr_err(ae2), .perr(pe2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    en = 1'b0; w = 1'b0; clr = 1'b0; pinj = 1'b0; addr = '0; d = '0;
  endtask

  // Count observed busy cycles of u0 and u2, bounded.
  task automatic count_busy(output int n0, output int n2);
    int guard;
    n0 = 0; n2 = 0; guard = 0;
    while ((busy0 || busy2) && guard < 40) begin
      if (busy0) n0++;
      if (busy2) n2++;
      guard++;
      step();
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] v, input logic pi);
    en = 1'b1; w = 1'b1; addr = a; d = v; pinj = pi;
    step();
    idle_in();
  endtask

  task automatic rd(input logic [2:0] a);
    en = 1'b1; w = 1'b0; addr = a;
    step();
    idle_in();
  endtask

  initial begin
    int n0, n2;
    idle_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("reset_busy", busy0, 1);
    check_eq("reset_out", out0, 8'h00);
    check_eq("reset_valid", ov0, 0);
    check_eq("reset_aerr", ae0, 0);
    count_busy(n0, n2);
    check_eq("reset_clear_len8", n0, 8);
    check_eq("reset_clear_len6", n2, 6);

    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check_eq($sformatf("init_rd%0d", a), {23'd0, ov0, out0}, {23'd0, 1'b1, 8'h00});
    end

    // Write / read
    wr(3'd1, 8'h01, 1'b0);
    check_eq("wr_noecho_valid", ov0, 0);
    check_eq("wr_echo", {ov1, out1}, {1'b1, 8'h01});
    wr(3'd4, 8'h0B, 1'b0);
    rd(3'd1);
    check_eq("rd_a1", {ov0, out0}, {1'b1, 8'h01});
    rd(3'd4);
    check_eq("rd_a4", {ov0, out0}, {1'b1, 8'h0B});
    step();
    check_eq("idle_hold", {ov0, ae0, pe0, out0}, {3'b000, 8'h0B});

    // Back-to-back write then read
    wr(3'd3, 8'hA5, 1'b0);
    rd(3'd3);
    check_eq("b2b_rd", {ov0, out0}, {1'b1, 8'hA5});

    // Echo mode comparison
    wr(3'd2, 8'h5A, 1'b0);
    check_eq("echo0_hold", {ov0, out0}, {1'b0, 8'hA5});
    check_eq("echo1", {ov1, out1}, {1'b1, 8'h5A});
    rd(3'd2);
    check_eq("echo_rd_back", {ov0, out0}, {1'b1, 8'h5A});

    // Range check on DEPTH=6
    rd(3'd7);
    check_eq("range_u2", {ov2, ae2, out2}, {2'b11, 8'h00});
    check_eq("range_u0_ok", {ov0, ae0}, 2'b10);
    wr(3'd6, 8'hEE, 1'b0);
    check_eq("range_wr_u2", {ov2, ae2}, 2'b01);
    step();
    check_eq("range_strobe_clear", ae2, 0);

    // clr with same-cycle en: access dropped, array cleared
    en = 1'b1; w = 1'b1; addr = 3'd0; d = 8'hFF; clr = 1'b1;
    step();
    idle_in();
    check_eq("clr_busy", busy0, 1);
    count_busy(n0, n2);
    check_eq("clr_len8", n0, 8);
    check_eq("clr_len6", n2, 6);
    rd(3'd0);
    check_eq("clr_a0", {ov0, out0}, {1'b1, 8'h00});
    rd(3'd4);
    check_eq("clr_a4", {ov0, out0}, {1'b1, 8'h00});
    rd(3'd3);
    check_eq("clr_u2_a3", {ov2, out2}, {1'b1, 8'h00});

    // Reset during clear cycle 3 restarts the full clear
    wr(3'd5, 8'h77, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(n0, n2);
    check_eq("midclr_len8", n0, 8);
    rd(3'd5);
    check_eq("midclr_a5", {ov0, out0}, {1'b1, 8'h00});

    // Parity
    wr(3'd5, 8'h03, 1'b1);
    rd(3'd5);
`ifdef RAM_PARITY_EN
    check_eq("par_inj", {ov0, pe0, out0}, {2'b11, 8'h03});
`else
    check_eq("par_off_inj", {ov0, pe0, out0}, {2'b10, 8'h03});
`endif
    wr(3'd5, 8'h03, 1'b0);
    rd(3'd5);
    check_eq("par_clean", {ov0, pe0, out0}, {2'b10, 8'h03});
    step();
    check_eq("par_strobe_idle", pe0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
